// File: rtl/pwm_shadow_register_file_if.sv
// pwm_shadow_register_file_if: byte-wide register bus for the PWM shadow register file.
// Signals: i_write_en (write strobe), i_address (byte address), i_data (write data) and o_data (read data).
// Modports: master drives the bus, and slave is the register file.
interface pwm_shadow_register_file_if #(parameter int ADDRESS_WIDTH = 5);
  logic                     i_write_en;
  logic [ADDRESS_WIDTH-1:0] i_address;
  logic [7:0]               i_data;
  logic [7:0]               o_data;
  modport master (output i_write_en, i_address, i_data, input o_data);
  modport slave (input i_write_en, i_address, i_data, output o_data);
endinterface

// File: rtl/pwm_shadow_register_file.sv
// pwm_shadow_register_file: multi-channel PWM register file with double-buffered timing registers.
// Ports:
//   i_clk, i_reset_n       the clock and an asynchronous active-low reset.
//   bus                    the byte register bus. The channel is address[AW-1:4] and the offset is address[3:0].
//   i_sync                 a per-channel period-boundary pulse. It commits staged data in shadow mode.
//   o_control              the per-channel control byte. Bit 0 is enable and bit 1 is SHADOW_EN.
//   o_period, o_*_comp*    the active 16-bit timing values, given as {msb, lsb}.
//   o_*_action/deadband    the active 8-bit registers.
//   o_pending              staged data that has not yet been committed to the active copy.
module pwm_shadow_register_file #(
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  pwm_shadow_register_file_if.slave  bus,
  input  logic [NUM_CHANNELS-1:0]    i_sync,
  output logic [NUM_CHANNELS*8-1:0]  o_control,
  output logic [NUM_CHANNELS*16-1:0] o_period,
  output logic [NUM_CHANNELS*16-1:0] o_a_compa,
  output logic [NUM_CHANNELS*16-1:0] o_a_compb,
  output logic [NUM_CHANNELS*16-1:0] o_b_compa,
  output logic [NUM_CHANNELS*16-1:0] o_b_compb,
  output logic [NUM_CHANNELS*8-1:0]  o_a_action,
  output logic [NUM_CHANNELS*8-1:0]  o_b_action,
  output logic [NUM_CHANNELS*8-1:0]  o_a_deadband,
  output logic [NUM_CHANNELS*8-1:0]  o_b_deadband,
  output logic [NUM_CHANNELS-1:0]    o_pending
);
  localparam int CW = ADDRESS_WIDTH > 4 ? ADDRESS_WIDTH - 4 : 1;
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || ADDRESS_WIDTH < 4 + $clog2(NUM_CHANNELS)) begin : g_bad_params
    $error("pwm_shadow_register_file: bad NUM_CHANNELS/ADDRESS_WIDTH");
  end
  logic [CW-1:0] ch;
  logic [3:0]    off;
  if (ADDRESS_WIDTH > 4) begin : g_ch
    assign ch = bus.i_address[ADDRESS_WIDTH-1:4];
  end else begin : g_ch0
    assign ch = '0;
  end
  assign off = bus.i_address[3:0];
  logic [7:0]       control   [NUM_CHANNELS];
  logic [7:0]       control_n [NUM_CHANNELS];
  logic [14:1][7:0] staged    [NUM_CHANNELS];
  logic [14:1][7:0] staged_n  [NUM_CHANNELS];
  logic [14:1][7:0] active    [NUM_CHANNELS];
  logic [14:1][7:0] active_n  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending, pending_n, hit, timing_wr, commit_req, pend_any;
  wire timing_off = off != 4'd0 && off != 4'd15;
  // A write that lands on the same edge as sync or force is folded into that commit.
  // This is done through pend_any, and the commit loads the next-state staged copy.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      hit[c]        = bus.i_write_en && int'(ch) == c;
      timing_wr[c]  = hit[c] && timing_off;
      control_n[c]  = (hit[c] && off == 4'd0) ? bus.i_data : control[c];
      staged_n[c]   = staged[c];
      if (timing_wr[c]) staged_n[c][off] = bus.i_data;
      commit_req[c] = i_sync[c] || (hit[c] && off == 4'd15 && bus.i_data[0]);
      pend_any[c]   = pending[c] || timing_wr[c];
      pending_n[c]  = control_n[c][1] && pend_any[c] && !commit_req[c];
      active_n[c]   = (!control_n[c][1] || (pend_any[c] && commit_req[c])) ? staged_n[c] : active[c];
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      control <= '{default: '0};
      staged  <= '{default: '0};
      active  <= '{default: '0};
      pending <= '0;
    end else begin
      control <= control_n;
      staged  <= staged_n;
      active  <= active_n;
      pending <= pending_n;
    end
  end
  always_comb begin
    bus.o_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (int'(ch) == c)
        bus.o_data = off == 4'd0  ? control[c] :
                     off == 4'd15 ? {6'b0, control[c][1], pending[c]} : staged[c][off];
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign o_control[8*c+:8]     = control[c];
    assign o_period[16*c+:16]    = {active[c][1], active[c][2]};
    assign o_a_action[8*c+:8]    = active[c][3];
    assign o_a_compa[16*c+:16]   = {active[c][4], active[c][5]};
    assign o_a_compb[16*c+:16]   = {active[c][6], active[c][7]};
    assign o_a_deadband[8*c+:8]  = active[c][8];
    assign o_b_action[8*c+:8]    = active[c][9];
    assign o_b_compa[16*c+:16]   = {active[c][10], active[c][11]};
    assign o_b_compb[16*c+:16]   = {active[c][12], active[c][13]};
    assign o_b_deadband[8*c+:8]  = active[c][14];
  end
  assign o_pending = pending;
endmodule

// File: tb/tb_pwm_shadow_register_file.sv
// tb_pwm_shadow_register_file: scoreboard bench for pwm_shadow_register_file.
module tb_pwm_shadow_register_file;
  localparam int NC = 2;
  localparam int AW = 6;
  logic clk = 0;
  logic rst_n = 0;
  logic [NC-1:0] sync = '0;
  logic [NC*8-1:0]  o_control, o_a_action, o_b_action, o_a_deadband, o_b_deadband;
  logic [NC*16-1:0] o_period, o_a_compa, o_a_compb, o_b_compa, o_b_compb;
  logic [NC-1:0]    o_pending;
  pwm_shadow_register_file_if #(.ADDRESS_WIDTH(AW)) bus();
  pwm_shadow_register_file #(.NUM_CHANNELS(NC), .ADDRESS_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .i_sync(sync),
    .o_control(o_control), .o_period(o_period),
    .o_a_compa(o_a_compa), .o_a_compb(o_a_compb), .o_b_compa(o_b_compa), .o_b_compb(o_b_compb),
    .o_a_action(o_a_action), .o_b_action(o_b_action),
    .o_a_deadband(o_a_deadband), .o_b_deadband(o_b_deadband), .o_pending(o_pending)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic expect_val(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic observe(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) check("sb_empty", obs, 32'hdead_beef);
    else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask
  task automatic wr(logic [AW-1:0] a, logic [7:0] d, logic [NC-1:0] s = '0);
    @(negedge clk);
    bus.i_write_en = 1'b1;
    bus.i_address = a;
    bus.i_data = d;
    sync = s;
    @(posedge clk);
    #1;
    bus.i_write_en = 1'b0;
    sync = '0;
  endtask
  task automatic cyc(logic [NC-1:0] s);
    @(negedge clk);
    sync = s;
    @(posedge clk);
    #1;
    sync = '0;
  endtask
  task automatic rd(string tag, logic [AW-1:0] a, logic [7:0] e);
    bus.i_address = a;
    expect_val(tag, {24'b0, e});
    #1;
    observe({24'b0, bus.o_data});
  endtask
  initial begin
    bus.i_write_en = 1'b0;
    bus.i_address = '0;
    bus.i_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_val("rst_ctrl", 0);
    expect_val("rst_pend", 0);
    expect_val("rst_period", 0);
    observe(o_control);
    observe(o_pending);
    observe(o_period);
    for (int a = 0; a < 16; a++) rd($sformatf("rst_rd%0d", a), AW'(a), 8'h00);
    expect_val("imm_ctrl", 32'h0001);
    wr(6'h00, 8'h01);
    observe(o_control);
    expect_val("imm_msb", 32'h1200);
    expect_val("imm_msb_pend", 0);
    wr(6'h01, 8'h12);
    observe(o_period[15:0]);
    observe(o_pending);
    expect_val("imm_lsb", 32'h1234);
    expect_val("imm_lsb_pend", 0);
    wr(6'h02, 8'h34);
    observe(o_period[15:0]);
    observe(o_pending);
    expect_val("sh_ctrl", 32'h0301);
    wr(6'h10, 8'h03);
    observe(o_control);
    expect_val("sh_msb_pend", 32'h2);
    expect_val("sh_msb_hold", 0);
    wr(6'h14, 8'h00);
    observe(o_pending);
    observe(o_a_compa[31:16]);
    expect_val("sh_lsb_pend", 32'h2);
    expect_val("sh_lsb_hold", 0);
    wr(6'h15, 8'h80);
    observe(o_pending);
    observe(o_a_compa[31:16]);
    rd("sh_staged_rd", 6'h15, 8'h80);
    expect_val("sync_val", 32'h0080);
    expect_val("sync_pend", 0);
    expect_val("sync_ch0_period", 32'h1234);
    expect_val("sync_ch0_compa", 0);
    cyc(2'b10);
    observe(o_a_compa[31:16]);
    observe(o_pending);
    observe(o_period[15:0]);
    observe(o_a_compa[15:0]);
    expect_val("sync_hold_val", 32'h0080);
    expect_val("sync_hold_pend", 0);
    cyc(2'b10);
    observe(o_a_compa[31:16]);
    observe(o_pending);
    expect_val("wsync_db", 32'h0A);
    expect_val("wsync_pend", 0);
    wr(6'h1E, 8'h0A, 2'b10);
    observe(o_b_deadband[15:8]);
    observe(o_pending);
    expect_val("force_pre_pend", 32'h2);
    expect_val("force_pre_act", 0);
    wr(6'h19, 8'h55);
    observe(o_pending);
    observe(o_b_action[15:8]);
    rd("status_pend", 6'h1F, 8'h03);
    expect_val("force_act", 32'h55);
    expect_val("force_pend", 0);
    wr(6'h1F, 8'h01);
    observe(o_b_action[15:8]);
    observe(o_pending);
    rd("status_clean", 6'h1F, 8'h02);
    expect_val("nof_pend", 32'h2);
    wr(6'h13, 8'h77);
    observe(o_pending);
    expect_val("nof_pend2", 32'h2);
    expect_val("nof_act", 0);
    wr(6'h1F, 8'hFE);
    observe(o_pending);
    observe(o_a_action[15:8]);
    rd("status_nof", 6'h1F, 8'h03);
    expect_val("clr_sh_act", 32'h77);
    expect_val("clr_sh_pend", 0);
    expect_val("clr_sh_ctrl", 32'h0101);
    wr(6'h10, 8'h01);
    observe(o_a_action[15:8]);
    observe(o_pending);
    observe(o_control);
    expect_val("unm_ctrl", 32'h0101);
    expect_val("unm_period", 32'h1234);
    expect_val("unm_pend", 0);
    expect_val("unm_db", 32'h0A00);
    wr(6'h25, 8'hFF);
    observe(o_control);
    observe(o_period[31:0]);
    observe(o_pending);
    observe(o_b_deadband);
    rd("unm_rd", 6'h25, 8'h00);
    rd("unm_rd_ch0", 6'h05, 8'h00);
    wr(6'h00, 8'h03);
    expect_val("ind_pend", 32'h1);
    wr(6'h04, 8'hAB);
    observe(o_pending);
    expect_val("ind_other_sync_pend", 32'h1);
    expect_val("ind_other_sync_act", 0);
    cyc(2'b10);
    observe(o_pending);
    observe(o_a_compa[15:0]);
    expect_val("ind_sync_act", 32'hAB00);
    expect_val("ind_sync_pend", 0);
    cyc(2'b01);
    observe(o_a_compa[15:0]);
    observe(o_pending);
    for (int c = 0; c < NC; c++) begin
      for (int o = 0; o < 15; o++) begin
        wr(AW'(c * 16 + o), 8'h5A);
        rd($sformatf("rb%0d_%0d", c, o), AW'(c * 16 + o), 8'h5A);
      end
      rd($sformatf("rb%0d_status", c), AW'(c * 16 + 15), 8'h03);
    end
    expect_val("rb_ctrl", 32'h5A5A);
    observe(o_control);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("ar_ctrl", 0);
    expect_val("ar_period", 0);
    expect_val("ar_acompa", 0);
    expect_val("ar_bdb", 0);
    expect_val("ar_baction", 0);
    expect_val("ar_pend", 0);
    observe(o_control);
    observe(o_period);
    observe(o_a_compa);
    observe(o_b_deadband);
    observe(o_b_action);
    observe(o_pending);
    for (int a = 0; a < 48; a++) rd($sformatf("ar_rd%0d", a), AW'(a), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
